// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO read-side arbiters: FSM state encoding and
// a constant-evaluable ceil(log2) used to size index and counter fields.
package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first asserted request strictly
// after 'last', searching circularly, plus a flag that any request is present.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic         any,
  output logic [W-1:0] idx
);

  int unsigned cand;
  logic [W-1:0] cand_idx;

  // Offsets 1..N cover every index once, ending with 'last' itself.
  always_comb begin
    any      = 1'b0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand     = (32'(last) + k) % N;
      cand_idx = W'(cand);
      if (!any && req[cand_idx]) begin
        any = 1'b1;
        idx = cand_idx;
      end
    end
  end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Round-robin burst arbiter draining NUM_SRC FIFO read ports into a single
// registered valid/ready stream, up to MAX_BURST words per grant.
module fifo_rd_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned NUM_SRC   = 4,
  parameter  int unsigned DSIZE     = 8,
  parameter  int unsigned MAX_BURST = 4,
  localparam int unsigned SRC_W     = clog2(NUM_SRC),
  localparam int unsigned CNT_W     = clog2(MAX_BURST + 1)
) (
  input  logic                     rclk,
  input  logic                     rrst,
  input  logic                     en,
  input  logic [NUM_SRC-1:0]       src_rempty,
  input  logic [NUM_SRC*DSIZE-1:0] src_rdata,
  output logic [NUM_SRC-1:0]       src_rinc,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DSIZE-1:0]         m_data,
  output logic [SRC_W-1:0]         m_src,
  output logic                     m_last,
  output logic                     busy
);

  state_t           state;
  state_t           state_nxt;
  logic [SRC_W-1:0] gnt;
  logic [SRC_W-1:0] last_gnt;
  logic [CNT_W-1:0] cnt;
  logic             pick_any;
  logic [SRC_W-1:0] pick_idx;
  logic             grant;
  logic             out_free;
  logic             pop;
  logic             cnt_last;
  logic [DSIZE-1:0] gnt_data;

  rr_pick #(
    .N (NUM_SRC),
    .W (SRC_W)
  ) u_pick (
    .req  (~src_rempty),
    .last (last_gnt),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  assign gnt_data = src_rdata[gnt*DSIZE +: DSIZE];
  assign out_free = ~m_valid | m_ready;
  assign cnt_last = (cnt == CNT_W'(MAX_BURST - 1));
  assign grant    = (state == ST_IDLE) & en & pick_any;
  assign busy     = (state == ST_GRANT) | m_valid;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // An empty granted source ends the burst without popping, even when stalled.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    src_rinc  = '0;
    case (state)
      ST_IDLE: begin
        if (grant) state_nxt = ST_GRANT;
      end
      ST_GRANT: begin
        if (src_rempty[gnt]) begin
          state_nxt = ST_IDLE;
        end else if (out_free) begin
          pop           = 1'b1;
          src_rinc[gnt] = 1'b1;
          if (cnt_last) state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      gnt      <= '0;
      last_gnt <= SRC_W'(NUM_SRC - 1);
      cnt      <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_src    <= '0;
      m_last   <= 1'b0;
    end else begin
      if (grant) begin
        gnt      <= pick_idx;
        last_gnt <= pick_idx;
        cnt      <= '0;
      end
      if (pop) begin
        m_data  <= gnt_data;
        m_src   <= gnt;
        m_valid <= 1'b1;
        m_last  <= cnt_last;
        cnt     <= cnt + CNT_W'(1);
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Scoreboard bench for fifo_rd_arbiter: behavioural FIFO sources, expected words
// queued by the stimulus, and a monitor comparing every accepted output word.
module tb_fifo_rd_arbiter;

  localparam int NS = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  typedef struct {
    logic [7:0] data;
    logic [1:0] src;
    logic       last;
  } exp_t;

  logic            rclk = 1'b0;
  logic            rrst = 1'b1;
  logic            en = 1'b0;
  logic            m_ready = 1'b0;
  logic [NS-1:0]   src_rempty = '1;
  logic [NS*DW-1:0] src_rdata = '0;
  logic [NS-1:0]   src_rinc;
  logic            m_valid;
  logic [DW-1:0]   m_data;
  logic [1:0]      m_src;
  logic            m_last;
  logic            busy;

  logic [7:0] mem [NS][64];
  int wr_ptr [NS] = '{default: 0};
  int rd_ptr [NS] = '{default: 0};
  int nr;

  exp_t exp_q[$];
  exp_t mon_e;
  int n_checks = 0;
  int n_fails  = 0;

  fifo_rd_arbiter #(
    .NUM_SRC   (NS),
    .DSIZE     (DW),
    .MAX_BURST (MB)
  ) dut (
    .rclk       (rclk),
    .rrst       (rrst),
    .en         (en),
    .src_rempty (src_rempty),
    .src_rdata  (src_rdata),
    .src_rinc   (src_rinc),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_src      (m_src),
    .m_last     (m_last),
    .busy       (busy)
  );

  always #5 rclk = ~rclk;

  // FIFO read side: flag and data registered on the same edge as the pop.
  always @(posedge rclk) begin
    for (int i = 0; i < NS; i++) begin
      nr = rrst ? wr_ptr[i] : rd_ptr[i] + (src_rinc[i] ? 1 : 0);
      rd_ptr[i]           <= nr;
      src_rempty[i]       <= (nr == wr_ptr[i]);
      src_rdata[i*DW +: DW] <= mem[i][nr % 64];
    end
  end

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int s, input int n, input int base);
    for (int k = 0; k < n; k++) begin
      mem[s][wr_ptr[s] % 64] = 8'(s * 64 + base + k);
      wr_ptr[s] = wr_ptr[s] + 1;
    end
  endtask

  task automatic expect_w(input int s, input int n, input logic last);
    exp_t e;
    e.data = 8'(s * 64 + n);
    e.src  = 2'(s);
    e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic wait_rinc(input string name, input logic [3:0] want, input int max);
    int k = 0;
    while (src_rinc == '0 && k < max) begin
      tick();
      k++;
    end
    chk(name, 32'(src_rinc), 32'(want));
  endtask

  task automatic wait_drain(input string name, input int max);
    int k = 0;
    while ((exp_q.size() != 0 || busy) && k < max) begin
      tick();
      k++;
    end
    chk({name, "_queue_left"}, exp_q.size(), 0);
    chk({name, "_busy"}, 32'(busy), 0);
  endtask

  // Monitor: every word accepted downstream must be the next expected one.
  initial begin
    forever begin
      @(negedge rclk);
      if (!rrst && m_valid && m_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fails++;
          $display("FAIL sb_unexpected: got data=%0h src=%0d last=%0b, expected no word",
                   m_data, m_src, m_last);
        end else begin
          mon_e = exp_q.pop_front();
          if (m_data !== mon_e.data || m_src !== mon_e.src || m_last !== mon_e.last) begin
            n_fails++;
            $display("FAIL sb_word: got data=%0h src=%0d last=%0b expected data=%0h src=%0d last=%0b",
                     m_data, m_src, m_last, mon_e.data, mon_e.src, mon_e.last);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pop_src[$];
    int pop_cyc[$];
    int cyc;
    int idx;
    int j;
    int nz;

    // Reset state
    repeat (3) tick();
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_src_rinc", 32'(src_rinc), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_outputs", {m_data, 6'(m_src), 1'b0, m_last}, 0);
    rrst = 1'b0;
    tick();

    // Test 1: three-word early-ended burst from source 0
    en = 1'b1;
    m_ready = 1'b1;
    push(0, 3, 0);
    for (int n = 0; n < 3; n++) expect_w(0, n, 1'b0);
    wait_rinc("t1_pop0", 4'b0001, 10);
    tick();
    chk("t1_pop1", 32'(src_rinc), 32'h1);
    tick();
    chk("t1_pop2", 32'(src_rinc), 32'h1);
    tick();
    chk("t1_no_pop3", 32'(src_rinc), 0);
    wait_drain("t1", 20);

    // Test 2: all sources hold 10 words; round-robin bursts of 4
    rrst = 1'b1;
    tick();
    rrst = 1'b0;
    tick();
    for (int s = 0; s < NS; s++) push(s, 10, 0);
    for (int r = 0; r < 3; r++)
      for (int s = 0; s < NS; s++)
        for (int n = r * 4; n < r * 4 + 4 && n < 10; n++)
          expect_w(s, n, (n - r * 4) == 3);
    cyc = 0;
    while (pop_src.size() < 40 && cyc < 300) begin
      if (src_rinc != '0) begin
        chk("t2_onehot", $countones(src_rinc), 1);
        idx = 0;
        for (int i = 0; i < NS; i++) if (src_rinc[i]) idx = i;
        pop_src.push_back(idx);
        pop_cyc.push_back(cyc);
      end
      tick();
      cyc++;
    end
    chk("t2_pop_count", pop_src.size(), 40);
    for (int b = 0; b < 12; b++) begin
      j = (b < 8) ? b * 4 : 32 + (b - 8) * 2;
      if (j < pop_src.size()) begin
        chk("t2_grant_src", pop_src[j], b % 4);
        if (b >= 1 && b <= 8) chk("t2_dead_cycle_gap", pop_cyc[j] - pop_cyc[j-1], 2);
      end
    end
    wait_drain("t2", 50);

    // Test 3: 5-cycle downstream stall mid-burst on source 1
    push(1, 4, 10);
    for (int n = 10; n < 14; n++) expect_w(1, n, n == 13);
    wait_rinc("t3_grant1", 4'b0010, 10);
    tick();
    tick();
    m_ready = 1'b0;
    repeat (5) begin
      #1;
      chk("t3_stall_valid", 32'(m_valid), 1);
      chk("t3_stall_data", 32'(m_data), 32'(8'(64 + 11)));
      chk("t3_stall_src", 32'(m_src), 1);
      chk("t3_stall_rinc", 32'(src_rinc), 0);
      tick();
    end
    m_ready = 1'b1;
    wait_drain("t3", 20);

    // Test 4: wrap search back to source 2, then 3 before 1
    push(2, 1, 10);
    expect_w(2, 10, 1'b0);
    wait_rinc("t4_prime2", 4'b0100, 10);
    wait_drain("t4a", 20);
    push(2, 1, 11);
    expect_w(2, 11, 1'b0);
    wait_rinc("t4_wrap2", 4'b0100, 10);
    wait_drain("t4b", 20);
    push(1, 1, 14);
    push(3, 1, 10);
    expect_w(3, 10, 1'b0);
    expect_w(1, 14, 1'b0);
    wait_rinc("t4_first3", 4'b1000, 10);
    tick();
    wait_rinc("t4_then1", 4'b0010, 10);
    wait_drain("t4c", 20);

    // Test 5: reset while a popped word is held
    m_ready = 1'b0;
    push(0, 4, 20);
    wait_rinc("t5_pop0", 4'b0001, 10);
    tick();
    chk("t5_held_valid", 32'(m_valid), 1);
    rrst = 1'b1;
    #1;
    chk("t5_rst_valid", 32'(m_valid), 0);
    chk("t5_rst_rinc", 32'(src_rinc), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    tick();
    tick();
    rrst = 1'b0;
    m_ready = 1'b1;
    push(1, 1, 15);
    push(3, 1, 11);
    expect_w(1, 15, 1'b0);
    expect_w(3, 11, 1'b0);
    wait_rinc("t5_first1", 4'b0010, 10);
    wait_drain("t5", 20);

    // Test 6: en gates new grants
    en = 1'b0;
    for (int s = 0; s < NS; s++) push(s, 2, 30);
    for (int s = 0; s < NS; s++) begin
      expect_w(s, 30, 1'b0);
      expect_w(s, 31, 1'b0);
    end
    nz = 0;
    repeat (20) begin
      tick();
      if (src_rinc != '0) nz++;
    end
    chk("t6_no_pop_disabled", nz, 0);
    chk("t6_idle_busy", 32'(busy), 0);
    en = 1'b1;
    tick();
    chk("t6_grant_busy", 32'(busy), 1);
    chk("t6_grant_valid", 32'(m_valid), 0);
    chk("t6_grant_rinc", 32'(src_rinc), 32'h1);
    tick();
    chk("t6_valid", 32'(m_valid), 1);
    chk("t6_src", 32'(m_src), 0);
    wait_drain("t6", 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
